// File: rtl/lsu_pkg.sv
// ============================================================================
// lsu_pkg : shared funct3 codes, FSM state encoding and access legality check
// Rev 1.0
// ============================================================================
`default_nettype none

package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_MERGE = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  // Stores only exist as signed-size codes; everything else must be naturally aligned.
  function automatic logic access_err(input logic i_we, input logic [2:0] i_f3,
                                      input logic [1:0] i_a);
    logic w_e;
    w_e = 1'b0;
    case (i_f3)
      F3_B:    w_e = 1'b0;
      F3_BU:   w_e = i_we;
      F3_H:    w_e = i_a[0];
      F3_HU:   w_e = i_we | i_a[0];
      F3_W:    w_e = |i_a;
      default: w_e = 1'b1;
    endcase
    return w_e;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_load_align.sv
// ============================================================================
// lsu_load_align : selects the addressed byte/half of a word and extends it
// Rev 1.0
// ============================================================================
`default_nettype none

module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_addr)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];

    o_data = i_word;
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_data = {24'd0, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_data = {16'd0, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_rmw.sv
// ============================================================================
// lsu_rmw : single-outstanding load/store unit; sub-word stores via read-modify-write
// Rev 1.0
// ============================================================================
`default_nettype none

module lsu_rmw
  import lsu_pkg::*;
#(
  parameter int ADDRW = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [ADDRW-1:0] req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  output logic [31:0]      resp_rdata,
  output logic             resp_err,
  output logic             mem_we,
  output logic [ADDRW-1:0] mem_addr,
  output logic [31:0]      mem_din,
  input  logic [31:0]      mem_dout
);

  state_t             r_state;
  state_t             w_next;
  logic [2:0]         r_funct3;
  logic [ADDRW-1:0]   r_addr;
  logic [15:0]        r_wdata;
  logic [31:0]        r_rdata;
  logic               r_err;
  logic [31:0]        r_din;
  logic               w_accept;
  logic               w_err;
  logic [31:0]        w_load;
  logic [31:0]        w_merged;

  assign w_accept   = req_valid && (r_state == ST_IDLE);
  assign w_err      = access_err(req_we, req_funct3, req_addr[1:0]);
  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = (r_state == ST_RESP);
  assign mem_we     = (r_state == ST_WRITE);
  assign mem_addr   = {r_addr[ADDRW-1:2], 2'b00};
  assign mem_din    = r_din;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  lsu_load_align u_align (
    .i_word   (mem_dout),
    .i_addr   (r_addr[1:0]),
    .i_funct3 (r_funct3),
    .o_data   (w_load)
  );

  always_comb begin
    w_merged = mem_dout;
    if (r_funct3 == F3_B) begin
      case (r_addr[1:0])
        2'd0:    w_merged[7:0]   = r_wdata[7:0];
        2'd1:    w_merged[15:8]  = r_wdata[7:0];
        2'd2:    w_merged[23:16] = r_wdata[7:0];
        default: w_merged[31:24] = r_wdata[7:0];
      endcase
    end else if (r_addr[1]) begin
      w_merged[31:16] = r_wdata;
    end else begin
      w_merged[15:0] = r_wdata;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_err)                   w_next = ST_RESP;
          else if (!req_we)            w_next = ST_LOAD;
          else if (req_funct3 == F3_W) w_next = ST_WRITE;
          else                         w_next = ST_MERGE;
        end
      end
      ST_LOAD:  w_next = ST_RESP;
      ST_MERGE: w_next = ST_WRITE;
      ST_WRITE: w_next = ST_RESP;
      ST_RESP:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // mem_din is preloaded with the store data at accept so SW needs no extra cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_din    <= '0;
    end else begin
      if (w_accept) begin
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata[15:0];
        r_rdata  <= '0;
        r_err    <= w_err;
        r_din    <= req_wdata;
      end
      if (r_state == ST_LOAD)  r_rdata <= w_load;
      if (r_state == ST_MERGE) r_din   <= w_merged;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu_rmw.sv
// ============================================================================
// tb_lsu_rmw : directed + random checks of lsu_rmw against a byte-array memory model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_lsu_rmw;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_din, mem_dout;

  logic [31:0] mem_words [16];
  logic [7:0]  ref_mem [64];
  logic        pre_en;
  logic [3:0]  pre_idx;
  logic [31:0] pre_val;
  int          checks = 0;
  int          failures = 0;
  int          we_count = 0;

  always #5 clk = ~clk;

  lsu_rmw #(.ADDRW(32)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  assign mem_dout = mem_words[mem_addr[5:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      mem_words[mem_addr[5:2]] <= mem_din;
      we_count <= we_count + 1;
    end else if (pre_en) begin
      mem_words[pre_idx] <= pre_val;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int a);
    int b;
    b = a & ~3;
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  function automatic bit ref_err(input bit we, input int f3, input int a);
    int size;
    if (f3 == 3 || f3 >= 6) return 1'b1;
    if (we && f3 >= 4) return 1'b1;
    size = 1 << (f3 % 4);
    return (a % size) != 0;
  endfunction

  // One request through the unit; expectations come from the byte-array model.
  task automatic do_req(input bit we, input logic [2:0] f3, input int a,
                        input logic [31:0] wd, input string tag);
    bit          e;
    int          size, lat, got, wecyc, we0, exp_wecyc;
    logic [31:0] exp_rd, exp_din;
    e = ref_err(we, int'(f3), a);
    size = 1 << f3[1:0];
    exp_rd = 0;
    exp_din = 0;
    if (!e && !we) begin
      for (int i = 0; i < size; i++) exp_rd |= 32'(ref_mem[a+i]) << (8*i);
      if (!f3[2] && size < 4 && exp_rd[8*size-1]) exp_rd |= 32'hFFFF_FFFF << (8*size);
    end
    if (!e && we) begin
      for (int i = 0; i < size; i++) ref_mem[a+i] = wd[8*i +: 8];
      exp_din = ref_word(a);
    end
    lat = e ? 1 : ((!we || f3 == 3'b010) ? 2 : 3);
    exp_wecyc = (we && !e) ? lat - 1 : 0;

    @(negedge clk);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    we0 = we_count;
    got = 0;
    wecyc = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_we) begin
        wecyc = k;
        check({tag, "_waddr"}, mem_addr, 32'(a & ~3));
        check({tag, "_wdata"}, mem_din, exp_din);
      end
      if (resp_valid) begin
        got = k;
        break;
      end
      check({tag, "_busy"}, 32'(req_ready), 32'd0);
    end
    check({tag, "_latency"}, 32'(got), 32'(lat));
    check({tag, "_rdata"}, resp_rdata, exp_rd);
    check({tag, "_err"}, 32'(resp_err), 32'(e));
    check({tag, "_wecycle"}, 32'(wecyc), 32'(exp_wecyc));
    check({tag, "_wecount"}, 32'(we_count - we0), 32'(exp_wecyc != 0));
    if (!e) check({tag, "_addr"}, mem_addr, 32'(a & ~3));
  endtask

  initial begin
    int we0;
    rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 0; req_wdata = 0; pre_en = 1'b0; pre_idx = 0; pre_val = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'($urandom);
    {ref_mem[19], ref_mem[18], ref_mem[17], ref_mem[16]} = 32'h8899AABB;
    for (int w = 0; w < 16; w++) begin
      @(negedge clk);
      pre_en = 1'b1; pre_idx = 4'(w); pre_val = ref_word(4*w);
    end
    @(negedge clk);
    pre_en = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_din", mem_din, 32'd0);
    rstn = 1'b1;

    do_req(0, 3'b000, 'h13, 0, "lb13");
    check("lb13_value", resp_rdata, 32'hFFFFFF88);
    do_req(0, 3'b100, 'h13, 0, "lbu13");
    check("lbu13_value", resp_rdata, 32'h00000088);
    do_req(0, 3'b001, 'h12, 0, "lh12");
    check("lh12_value", resp_rdata, 32'hFFFF8899);
    do_req(0, 3'b101, 'h10, 0, "lhu10");
    check("lhu10_value", resp_rdata, 32'h0000AABB);
    do_req(1, 3'b000, 'h11, 32'h123456CC, "sb11");
    do_req(0, 3'b010, 'h10, 0, "lw10");
    check("lw10_value", resp_rdata, 32'h8899CCBB);
    do_req(1, 3'b010, 'h14, 32'hDEADBEEF, "sw14");
    do_req(1, 3'b001, 'h16, 32'h0000CAFE, "sh16");
    do_req(0, 3'b010, 'h14, 0, "lw14");
    check("lw14_value", resp_rdata, 32'hCAFEBEEF);
    do_req(0, 3'b001, 'h11, 0, "err_lh11");
    do_req(1, 3'b010, 'h12, 32'h1, "err_sw12");
    do_req(1, 3'b100, 'h18, 32'h1, "err_sb_f3_100");

    // Back-to-back: req_valid stays high across two SB requests.
    we0 = we_count;
    ref_mem[32] = 8'h5A;
    ref_mem[34] = 8'hA5;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h20; req_wdata = 32'h5A;
    @(posedge clk);
    #1 req_addr = 32'h22; req_wdata = 32'hA5;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("b2b_busy", 32'(req_ready), 32'd0);
    end
    check("b2b_resp1", 32'(resp_valid), 32'd1);
    @(negedge clk);
    check("b2b_idle_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 3; k++) @(negedge clk);
    check("b2b_resp2", 32'(resp_valid), 32'd1);
    check("b2b_wecount", 32'(we_count - we0), 32'd2);
    check("b2b_word", mem_words[8], ref_word(32));

    // Reset while in MERGE of SB 0x10: nothing may reach memory.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h10; req_wdata = 32'h77;
    @(posedge clk);
    #1 req_valid = 1'b0;
    we0 = we_count;
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("rstm_ready", 32'(req_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      check("rstm_no_resp", 32'(resp_valid), 32'd0);
      check("rstm_no_we", 32'(mem_we), 32'd0);
      @(negedge clk);
    end
    check("rstm_wecount", 32'(we_count - we0), 32'd0);
    check("rstm_word", mem_words[4], ref_word(16));

    for (int n = 0; n < 60; n++)
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             int'($urandom_range(0, 63)), $urandom, "rand");

    @(negedge clk);
    for (int w = 0; w < 16; w++) check("final_mem", mem_words[w], ref_word(4*w));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lsu_rmw.md
Name: lsu_rmw

Overview:
- Load/store unit: the initiator side of the core's word-wide data memory port.
- Accepts one RISC-V load/store request at a time from the core (LB/LH/LW/LBU/LHU/SB/SH/SW).
- Drives word-aligned memory accesses and performs sub-word load extraction and sign/zero extension.
- Data memory writes whole words only, so SB/SH are done as read-modify-write. Returns one response per request.

Parameters:
- ADDRW, 32, width of req_addr and mem_addr.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rstn  in  1  synchronous active-low reset.
- req_valid  in  1  core request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 size/sign code.
- req_addr  in  ADDRW  byte address.
- req_wdata  in  32  store data; low byte/half used for SB/SH.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  extended load result; 0 for stores and errors.
- resp_err  out  1  misaligned access or illegal funct3; qualified by resp_valid.
- mem_we  out  1  word write enable to data memory.
- mem_addr  out  ADDRW  word-aligned address, {addr[ADDRW-1:2],2'b00}.
- mem_din  out  32  write word.
- mem_dout  in  32  read word; combinational (same-cycle) in mem_addr, writes land at posedge when mem_we.

Behaviour:
- Reset (rstn=0 at posedge):
  - state=IDLE; all latched request registers 0.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - mem_we=0 (decoded from state), mem_addr=0, mem_din=0.
- States: IDLE, LOAD, MERGE, WRITE, RESP.
- req_ready=1 only in IDLE. Handshake is req_valid&req_ready at a posedge: latch we/funct3/addr/wdata.
- Accept-time check; error if any of:
  - funct3 in {011,110,111};
  - store with funct3 in {100,101};
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0.
- Transitions from IDLE on accept:
  - error -> RESP with resp_err=1, rdata=0, no memory access;
  - load -> LOAD;
  - SW -> WRITE;
  - SB/SH -> MERGE.
- LOAD:
  - mem_addr = latched aligned address.
  - Sample mem_dout; select byte addr[1:0] or half addr[1].
  - Extend: LB/LH sign, LBU/LHU zero, LW as-is.
  - Register the result into resp_rdata. -> RESP.
- MERGE:
  - Sample mem_dout and replace the addressed byte lane (addr[1:0]) or half lane (addr[1]) with req_wdata[7:0] or [15:0].
  - Register the merged word into mem_din. -> WRITE.
- WRITE:
  - mem_we=1 for exactly this cycle.
  - mem_din = req_wdata (SW) or the merged word. -> RESP.
- RESP:
  - resp_valid=1 for exactly one cycle; no backpressure. -> IDLE.
  - resp_rdata/resp_err hold until the next accept.
- Latency, with accept at edge T and resp_valid high during cycle T+n:
  - error n=1;
  - load n=2;
  - SW n=2;
  - SB/SH n=3, with mem_we in cycle T+2.
- Throughput: the next accept is possible at the edge ending the RESP cycle+1 (IDLE). req_valid is ignored while not IDLE.
- mem_we is asserted only in WRITE; mem_addr is stable for all non-IDLE cycles of a request.
- Reset mid-operation: the next state is IDLE; no pending write is issued and no response is produced. A reset in MERGE must leave memory unchanged.
- Only one outstanding request exists, so there is no forwarding or hazard logic.

Decomposition:
- Package lsu_pkg:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101;
  - state encoding localparams;
  - function for the alignment/legality check.
- Sub-module lsu_load_align: combinational; inputs word, addr[1:0], funct3; output extended 32-bit result. Used in LOAD.
- Lane merge stays inline.

Test Plan:
- Preload word 0x10=0x8899AABB; LB 0x13 -> resp_valid at T+2, rdata=0xFFFFFF88, err=0. LBU 0x13 -> 0x00000088. LH 0x12 -> 0xFFFF8899. LHU 0x10 -> 0x0000AABB.
- SB addr 0x11, wdata 0x123456CC -> mem_we high only in T+2, mem_addr=0x10, mem_din=0x8899CCBB; resp at T+3 with rdata=0. Subsequent LW 0x10 -> 0x8899CCBB.
- SW 0x14, wdata 0xDEADBEEF -> mem_we in T+1, resp T+2; then SH 0x16 wdata 0x0000CAFE -> word becomes 0xCAFEBEEF.
- Errors: LH 0x11, SW 0x12, SB with funct3=100 -> resp_valid at T+1, err=1, rdata=0, mem_we never asserted.
- Back-to-back: hold req_valid=1 for two SB requests -> req_ready low T+1..T+3, second accepted at the next IDLE edge, exactly two mem_we pulses.
- Assert rstn=0 for one edge during MERGE of SB 0x10 -> no mem_we, no resp_valid, memory word unchanged, req_ready=1 the cycle after reset.
